// File: rtl/machine_pkg.sv
// Shared types and sizing for the solver scheduler and its round-robin arbiters.
package machine_pkg;

  localparam int unsigned SOLVER_UNITS     = 4;
  localparam int unsigned MAX_WIRING_WIDTH = 10;
  localparam int unsigned PRESS_WIDTH      = 4;
  localparam int unsigned RESULT_WIDTH     = 16;

  typedef logic [MAX_WIRING_WIDTH-1:0] wiring_t;
  typedef logic [PRESS_WIDTH-1:0]      press_count_t;
  typedef logic [RESULT_WIDTH-1:0]     result_t;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StDone
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after the pointer,
// and on advance moves the pointer to one past the winner.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_found;
  int unsigned   w_cand;

  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = (32'(r_ptr) + k) % N;
      if (!w_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        w_idx           = PW'(w_cand);
        w_found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/machine_solver_scheduler.sv
// Dispatches wiring lines to idle solver units and gathers their results into
// running press / failure totals; signals done after end-of-file drains.
module machine_solver_scheduler
  import machine_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [MAX_WIRING_WIDTH-1:0]         in_data,
  input  logic                                in_end_of_line,
  input  logic                                in_end_of_file,
  output logic                                in_ready,
  input  logic [SOLVER_UNITS-1:0]             unit_ready,
  output logic [SOLVER_UNITS-1:0]             unit_wiring_valid,
  output logic [MAX_WIRING_WIDTH-1:0]         unit_wiring_data,
  output logic                                unit_end_of_line,
  input  logic [SOLVER_UNITS-1:0]             unit_result_valid,
  input  logic [SOLVER_UNITS-1:0]             unit_result_failed,
  input  logic [SOLVER_UNITS*PRESS_WIDTH-1:0] unit_press_count,
  output logic [SOLVER_UNITS-1:0]             unit_result_ack,
  output logic [RESULT_WIDTH-1:0]             total_presses,
  output logic [7:0]                          fail_count,
  output logic                                done
);

  sched_state_e                r_state, w_state_d;
  logic [SOLVER_UNITS-1:0]     r_grant;
  logic [SOLVER_UNITS-1:0]     r_wvalid;
  wiring_t                     r_wdata;
  logic                        r_weol;
  logic [SOLVER_UNITS-1:0]     r_ack;
  result_t                     r_total;
  logic [7:0]                  r_fail;

  logic [SOLVER_UNITS-1:0]     w_disp_req, w_disp_grant;
  logic [SOLVER_UNITS-1:0]     w_res_req, w_res_grant;
  logic                        w_disp_adv;
  logic                        w_accept;
  logic                        w_ack_failed;
  press_count_t                w_ack_press;

  // A unit still seeing its final strobe has not yet dropped ready; keep it out of selection.
  assign w_disp_req = unit_ready & ~r_wvalid;
  // The unit being acked clears its valid only after this cycle; mask it to avoid a double pop.
  assign w_res_req  = unit_result_valid & ~r_ack;
  assign w_accept   = in_ready && in_valid;

  rr_arbiter #(.N(SOLVER_UNITS)) u_disp_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_disp_req),
    .i_advance (w_disp_adv),
    .o_grant   (w_disp_grant)
  );

  rr_arbiter #(.N(SOLVER_UNITS)) u_res_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_res_req),
    .i_advance (1'b1),
    .o_grant   (w_res_grant)
  );

  always_comb begin
    w_state_d  = r_state;
    w_disp_adv = 1'b0;
    in_ready   = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_end_of_file && !in_valid) begin
          w_state_d = StDrain;
        end else if (|w_disp_req) begin
          w_disp_adv = 1'b1;
          w_state_d  = StStream;
        end
      end
      StStream: begin
        in_ready = 1'b1;
        if (in_valid && in_end_of_line) w_state_d = StIdle;
      end
      StDrain: begin
        if ((&unit_ready) && !(|unit_result_valid) && !(|r_ack)) w_state_d = StDone;
      end
      StDone:  done = 1'b1;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_ack_failed = 1'b0;
    w_ack_press  = '0;
    for (int unsigned i = 0; i < SOLVER_UNITS; i++) begin
      if (r_ack[i]) begin
        w_ack_failed = unit_result_failed[i];
        w_ack_press  = unit_press_count[i*PRESS_WIDTH +: PRESS_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_grant  <= '0;
      r_wvalid <= '0;
      r_wdata  <= '0;
      r_weol   <= 1'b0;
      r_ack    <= '0;
      r_total  <= '0;
      r_fail   <= '0;
    end else begin
      r_state  <= w_state_d;
      if (w_disp_adv) r_grant <= w_disp_grant;
      r_wvalid <= w_accept ? r_grant : '0;
      r_weol   <= w_accept && in_end_of_line;
      if (w_accept) r_wdata <= in_data;
      r_ack    <= w_res_grant;
      if (|r_ack) begin
        if (w_ack_failed) begin
          if (r_fail != 8'hFF) r_fail <= r_fail + 8'd1;
        end else begin
          r_total <= r_total + RESULT_WIDTH'(w_ack_press);
        end
      end
    end
  end

  assign unit_wiring_valid = r_wvalid;
  assign unit_wiring_data  = r_wdata;
  assign unit_end_of_line  = r_weol;
  assign unit_result_ack   = r_ack;
  assign total_presses     = r_total;
  assign fail_count        = r_fail;

endmodule

// File: tb/tb_machine_solver_scheduler.sv
// Scoreboard bench: drivers push expected dispatches/results, a monitor pops and compares.
module tb_machine_solver_scheduler;
  import machine_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_end_of_line, in_end_of_file, in_ready;
  logic [9:0]  in_data;
  logic [3:0]  unit_ready, unit_wiring_valid, unit_result_valid, unit_result_failed;
  logic [3:0]  unit_result_ack;
  logic [9:0]  unit_wiring_data;
  logic        unit_end_of_line;
  logic [15:0] unit_press_count;
  logic [15:0] total_presses;
  logic [7:0]  fail_count;
  logic        done;

  // Unit models owned by the bench
  logic [3:0] ready_mask, hold, inj_en, res_fail;
  logic [3:0] res_cnt [4];
  int         cyc;

  assign unit_ready         = ready_mask;
  assign unit_result_valid  = hold;
  assign unit_result_failed = res_fail;
  for (genvar g = 0; g < 4; g++) begin : g_press
    assign unit_press_count[g*4 +: 4] = res_cnt[g];
  end

  machine_solver_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_end_of_line     (in_end_of_line),
    .in_end_of_file     (in_end_of_file),
    .in_ready           (in_ready),
    .unit_ready         (unit_ready),
    .unit_wiring_valid  (unit_wiring_valid),
    .unit_wiring_data   (unit_wiring_data),
    .unit_end_of_line   (unit_end_of_line),
    .unit_result_valid  (unit_result_valid),
    .unit_result_failed (unit_result_failed),
    .unit_press_count   (unit_press_count),
    .unit_result_ack    (unit_result_ack),
    .total_presses      (total_presses),
    .fail_count         (fail_count),
    .done               (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      hold <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (unit_result_ack[i]) hold[i] <= 1'b0;
        if (inj_en[i]) hold[i] <= 1'b1;
      end
    end
  end

  typedef struct {int unit; logic [9:0] data; bit eol; int cyc;} word_t;
  typedef struct {int unit; int cnt; bit f;} res_t;
  word_t       wq[$];
  res_t        rq[$];
  int          ack_log_u[$];
  int          ack_log_c[$];
  logic [15:0] mdl_total;
  int          mdl_fail;
  int          mdl_ptr;
  int          mon_total = 0, mon_bad = 0, tst_total = 0, tst_bad = 0;

  task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
    mon_total++;
    if (act !== exp) begin
      mon_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tst_total++;
    if (act !== exp) begin
      tst_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a word or acks a result.
  initial begin : monitor
    word_t e;
    int    idx, pos;
    bit    ack_prev;
    ack_prev = 1'b0;
    mdl_total = '0;
    mdl_fail  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wq.delete(); rq.delete(); ack_log_u.delete(); ack_log_c.delete();
        mdl_total = '0; mdl_fail = 0; ack_prev = 1'b0;
      end else begin
        if (unit_wiring_valid != '0) begin
          if (wq.size() == 0) begin
            mchk("word_unexpected", 32'(unit_wiring_valid), 32'd0);
          end else begin
            e = wq.pop_front();
            mchk("word_unit", 32'(unit_wiring_valid), 32'(1) << e.unit);
            mchk("word_data", 32'(unit_wiring_data), 32'(e.data));
            mchk("word_eol", 32'(unit_end_of_line), 32'(e.eol));
            mchk("word_latency", cyc, e.cyc);
          end
        end
        if (ack_prev) begin
          mchk("total_presses", 32'(total_presses), 32'(mdl_total));
          mchk("fail_count", 32'(fail_count), mdl_fail);
        end
        ack_prev = 1'b0;
        if (unit_result_ack != '0) begin
          mchk("ack_onehot", 32'($onehot(unit_result_ack)), 32'd1);
          idx = 0;
          for (int i = 0; i < 4; i++) if (unit_result_ack[i]) idx = i;
          mchk("ack_held", 32'(hold[idx]), 32'd1);
          pos = -1;
          for (int i = 0; i < rq.size(); i++) if (pos < 0 && rq[i].unit == idx) pos = i;
          mchk("ack_expected", pos >= 0, 32'd1);
          if (pos >= 0) begin
            if (rq[pos].f) mdl_fail = (mdl_fail < 255) ? mdl_fail + 1 : 255;
            else mdl_total = mdl_total + 16'(rq[pos].cnt);
            rq.delete(pos);
          end
          ack_log_u.push_back(idx);
          ack_log_c.push_back(cyc);
          ack_prev = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    in_valid = 1'b0; in_end_of_line = 1'b0; in_end_of_file = 1'b0;
    inj_en = '0;
    repeat (2) @(negedge clk);
    mdl_ptr = 0;
    #1 rst = 1'b0;
  endtask

  // Sends one line; the next line's ready mask is applied alongside the end-of-line word.
  task automatic send_line(input int nw, input logic [3:0] next_mask, input bit eof_last,
                           input int gap_max, output int stall);
    int u, g;
    u = -1;
    for (int k = 0; k < 4; k++) if (u < 0 && ready_mask[(mdl_ptr + k) % 4]) u = (mdl_ptr + k) % 4;
    mdl_ptr = (u + 1) % 4;
    stall = 0;
    for (int w = 0; w < nw; w++) begin
      if (w > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      in_valid       = 1'b1;
      in_data        = 10'($urandom);
      in_end_of_line = (w == nw - 1);
      if (eof_last && w == nw - 1) in_end_of_file = 1'b1;
      g = 0;
      while (!in_ready && g < 200) begin
        @(negedge clk); g++;
        if (w == 0) stall++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      if (w == nw - 1) ready_mask = next_mask;
      wq.push_back('{u, in_data, (w == nw - 1), cyc + 1});
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_end_of_line = 1'b0;
  endtask

  task automatic inject(input int u, input int cnt, input bit f);
    int g;
    g = 0;
    while ((hold[u] || inj_en[u]) && g < 300) begin @(negedge clk); g++; end
    chk("inject_slot", 32'(hold[u]), 32'd0);
    res_cnt[u] = cnt[3:0]; res_fail[u] = f; inj_en[u] = 1'b1;
    rq.push_back('{u, cnt, f});
    @(negedge clk);
    inj_en[u] = 1'b0;
  endtask

  task automatic wait_results();
    int g;
    g = 0;
    while ((rq.size() != 0 || hold != '0) && g < 500) begin @(negedge clk); g++; end
    chk("results_drained", rq.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int st, g, dcyc;
    cyc = 0; rst = 1'b1; in_data = '0; inj_en = '0; hold = '0;
    res_fail = '0; ready_mask = 4'b1111; mdl_ptr = 0;
    for (int i = 0; i < 4; i++) res_cnt[i] = '0;
    do_reset();
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_total", 32'(total_presses), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // Three 2-word lines to units 0,1,2 with a single bubble between lines
    for (int l = 0; l < 3; l++) begin
      send_line(2, (l == 2) ? 4'b0000 : 4'b1111, 1'b0, 0, st);
      chk("line_bubble", st, 32'd1);
    end

    // No unit ready: stall, then only unit 2 rises
    in_valid = 1'b1; in_end_of_line = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    ready_mask = 4'b0100;
    send_line(1, 4'b1111, 1'b0, 0, st);

    // Simultaneous results on units 0 and 3
    res_cnt[0] = 4'd3; res_cnt[3] = 4'd5; res_fail = '0;
    rq.push_back('{0, 3, 1'b0}); rq.push_back('{3, 5, 1'b0});
    inj_en = 4'b1001;
    @(negedge clk); inj_en = '0;
    wait_results();
    chk("ack_first", ack_log_u[0], 32'd0);
    chk("ack_second", ack_log_u[1], 32'd3);
    chk("ack_consecutive", ack_log_c[1] - ack_log_c[0], 32'd1);
    chk("total_8", 32'(total_presses), 32'd8);

    // Failed result leaves the press total alone
    inject(1, 7, 1'b1);
    wait_results();
    chk("fail_1", 32'(fail_count), 32'd1);
    chk("total_still_8", 32'(total_presses), 32'd8);

    // Random lines and results in parallel
    fork
      begin
        for (int l = 0; l < 20; l++)
          send_line($urandom_range(1, 4), (l == 19) ? 4'b1110 : 4'($urandom_range(1, 15)),
                    1'b0, 2, st);
      end
      begin
        for (int r = 0; r < 15; r++) begin
          inject($urandom_range(0, 3), $urandom_range(0, 15), ($urandom_range(0, 3) == 0));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join
    wait_results();

    // EOF after two lines while unit 0 is busy for ten cycles
    send_line(2, 4'b1110, 1'b0, 1, st);
    send_line(2, 4'b1110, 1'b1, 1, st);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("done_early", 32'(done), 32'd0);
    end
    ready_mask = 4'b1111;
    inject(0, 2, 1'b0);
    g = 0;
    while (!done && g < 50) begin @(negedge clk); g++; end
    dcyc = cyc;
    chk("done_rise", 32'(done), 32'd1);
    chk("done_after_ack", 32'(dcyc > ack_log_c[ack_log_c.size() - 1]), 32'd1);
    repeat (5) @(negedge clk);
    chk("done_sticky", 32'(done), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("words_drained", wq.size(), 32'd0);

    // Reset mid-STREAM
    in_end_of_file = 1'b0;
    do_reset();
    send_line(0, 4'b1111, 1'b0, 0, st);
    g = 0;
    in_valid = 1'b1; in_end_of_line = 1'b0; in_data = 10'h2a5;
    while (!in_ready && g < 20) begin @(negedge clk); g++; end
    wq.push_back('{0, in_data, 1'b0, cyc + 1});
    mdl_ptr = 1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wvalid", 32'(unit_wiring_valid), 32'd0);
    chk("rst_wdata", 32'(unit_wiring_data), 32'd0);
    chk("rst_total", 32'(total_presses), 32'd0);
    chk("rst_fail", 32'(fail_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    mdl_ptr = 0;
    #1 rst = 1'b0;
    send_line(1, 4'b1111, 1'b0, 0, st);
    @(negedge clk);
    chk("fresh_line_drained", wq.size(), 32'd0);

    // Empty file: EOF before any line
    @(negedge clk); #1 rst = 1'b1;
    in_end_of_file = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_total", 32'(total_presses), 32'd0);
    chk("empty_fail", 32'(fail_count), 32'd0);

    repeat (2) @(negedge clk);
    tst_total += mon_total;
    tst_bad   += mon_bad;
    $display("test done: total=%0d bad=%0d", tst_total, tst_bad);
    $finish;
  end

endmodule

// File: doc/machine_solver_scheduler.md
Name: machine_solver_scheduler

Overview:
- Sequences a pool of machine_wiring_solver units and replaces the fixed one-hot dispatch with a real scheduler.
- Accepts the decoded per-line wiring stream under backpressure and grants each machine line to one idle solver, using a rotating priority.
- Collects solver results through a round-robin acknowledge arbiter and accumulates the total button-press count.
- Raises completion only when end-of-file has been seen, every unit is idle and every result has been drained.

Parameters:
- SOLVER_UNITS, 4, number of solver units scheduled.
- MAX_WIRING_WIDTH, 10, width of one wiring word.
- PRESS_WIDTH, 4, width of one unit's press count (clog2(MAX_BUTTON_WIRINGS+1)).
- RESULT_WIDTH, 16, width of the accumulated total.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  wiring word present on in_data.
- in_data  in  MAX_WIRING_WIDTH  wiring word.
- in_end_of_line  in  1  qualifies in_valid; the word is the last of its line.
- in_end_of_file  in  1  level; no further lines will follow.
- in_ready  out  1  word accepted when in_valid && in_ready.
- unit_ready  in  SOLVER_UNITS  unit idle and able to take a new line.
- unit_wiring_valid  out  SOLVER_UNITS  one-hot strobe of the forwarded word.
- unit_wiring_data  out  MAX_WIRING_WIDTH  forwarded word, broadcast to all units.
- unit_end_of_line  out  1  broadcast; qualifies the strobe.
- unit_result_valid  in  SOLVER_UNITS  unit holds a result until acknowledged.
- unit_result_failed  in  SOLVER_UNITS  the held result is a failure.
- unit_press_count  in  SOLVER_UNITS*PRESS_WIDTH  flattened; unit i occupies bits [i*PRESS_WIDTH +: PRESS_WIDTH].
- unit_result_ack  out  SOLVER_UNITS  one-hot pop of a held result.
- total_presses  out  RESULT_WIDTH  running sum of press counts.
- fail_count  out  8  number of failed machines.
- done  out  1  sticky completion flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, grant pointer 0, accumulators 0. Reset mid-line abandons the line; units are reset by the same rst.
- IDLE:
  - If in_end_of_file is set and no word is pending, go to DRAIN.
  - Else, if any unit_ready bit is set, latch the first ready unit at or after the rotating pointer into grant, advance the pointer to grant+1 (mod SOLVER_UNITS) and go to STREAM.
  - in_ready stays 0 throughout IDLE.
- STREAM:
  - in_ready = 1 (combinational).
  - Each accepted word is registered: one cycle later unit_wiring_valid = grant, unit_wiring_data = word, unit_end_of_line = in_end_of_line.
  - Dispatch latency is 1 cycle.
  - Accepting the end_of_line word returns the FSM to IDLE, with in_ready = 0 from the next cycle.
  - Back-to-back lines therefore lose exactly one bubble cycle, spent in IDLE for unit selection.
- DRAIN: waits until all unit_ready bits are set, unit_result_valid is all zero and the ack pipeline is empty, then goes to DONE.
- DONE: done = 1; holds until rst; in_ready = 0.
- Result arbiter (runs in every state):
  - Each cycle, at most one unit_result_ack bit is raised: the round-robin winner among the unit_result_valid bits.
  - Arbiter priority is independent of the grant pointer.
  - The ack is registered; its bit stays clear while the same unit's valid is still being cleared, so no double pop.
  - On ack: if failed, fail_count += 1 (saturating at 255); else total_presses += press count, zero-extended, wrapping modulo 2^RESULT_WIDTH.
  - Accumulators update the cycle after the ack.
- Simultaneous events:
  - A result ack and a dispatch in the same cycle are independent.
  - A unit finishing a result while being granted is legal, because the grant only requires unit_ready.
- Boundary cases:
  - No unit ready: the scheduler stalls in IDLE indefinitely with in_ready = 0.
  - in_end_of_file asserted together with the last end_of_line word: that word is dispatched, then the FSM goes IDLE -> DRAIN.
  - Empty file (EOF while in IDLE before any line): DRAIN -> DONE within 2 cycles, totals 0.

Decomposition:
- Shared package (machine_pkg):
  - wiring_t
  - press_count_t
  - result_t
  - the scheduler state enum {IDLE, STREAM, DRAIN, DONE}
  - SOLVER_UNITS
- One sub-module: rr_arbiter (parameter N; inputs req and advance; output one-hot grant; rotating priority). It is instantiated twice: once for line dispatch over unit_ready, once for result pop over unit_result_valid.

Test Plan:
- 4 ready units, 3 lines of 2 words each -> lines strobe units 0, 1, 2 in order; each word appears 1 cycle after acceptance; one bubble between lines.
- Only unit 2 ready, 1 line -> grant = 0b0100; in_ready held 0 while unit_ready = 0, then the line streams when unit 2 rises.
- Units 0 and 3 assert results with counts 3 and 5 in the same cycle -> acks on two consecutive cycles in round-robin order; total_presses = 8.
- Unit 1 returns a failed result with count 7 -> fail_count = 1, total_presses unchanged.
- EOF after 2 lines, with one result held for 10 cycles -> done rises only after that ack and once all units are ready; remains high.
- rst pulsed mid-STREAM -> all outputs 0 next cycle; a fresh line then dispatches to unit 0.
